// File: rtl/toast_boot_mem_if.sv
// rtl/toast_boot_mem_if.sv - core fetch/load-store and boot-image load bus for toast_boot_mem
//
// Purpose : bundles the instruction port, the data port, the boot-image load
//           stream and the core-control outputs of the boot memory.
// Modports: slave  - the memory block (drives IMEM_data, DMEM_rd_data,
//                    Load_ready, Core_reset_n, Load_done, Addr_fault)
//           master - the core/loader side (drives all addresses, write data,
//                    strobes and the load stream)
interface toast_boot_mem_if;
    logic [31:0] IMEM_addr;
    logic [31:0] IMEM_data;
    logic [31:0] DMEM_addr;
    logic [31:0] DMEM_rd_data;
    logic [31:0] DMEM_wr_data;
    logic [3:0]  DMEM_wr_byte_en;
    logic        DMEM_wr_en;
    logic        DMEM_rst;
    logic        Load_valid;
    logic [31:0] Load_data;
    logic        Load_last;
    logic        Load_ready;
    logic        Core_reset_n;
    logic        Load_done;
    logic        Addr_fault;

    modport slave (
        input  IMEM_addr, DMEM_addr, DMEM_wr_data, DMEM_wr_byte_en, DMEM_wr_en,
               DMEM_rst, Load_valid, Load_data, Load_last,
        output IMEM_data, DMEM_rd_data, Load_ready, Core_reset_n, Load_done,
               Addr_fault
    );

    modport master (
        output IMEM_addr, DMEM_addr, DMEM_wr_data, DMEM_wr_byte_en, DMEM_wr_en,
               DMEM_rst, Load_valid, Load_data, Load_last,
        input  IMEM_data, DMEM_rd_data, Load_ready, Core_reset_n, Load_done,
               Addr_fault
    );
endinterface

// File: rtl/toast_boot_mem.sv
// rtl/toast_boot_mem.sv - boot memory: streams an image in, then serves ToastCore fetch/load/store
//
// Purpose : in LOAD the block accepts boot-image words into consecutive memory
//           words starting at 0 while holding the core in reset; after the
//           final word it enters RUN, releases the core and serves one
//           instruction read port plus one data read/write port.
// Ports   : Clk    - single clock, rising edge
//           Reset  - synchronous, active-high; returns to LOAD, memory kept
//           bus    - toast_boot_mem_if.slave (IMEM, DMEM, load stream, status)
module toast_boot_mem #(
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_W      = 14
) (
    input  logic             Clk,
    input  logic             Reset,
    toast_boot_mem_if.slave  bus
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   ld_ptr;
    logic [ADDR_W-1:0]   next_ptr;
    logic                handshake;

    logic [31:0]         mem [DEPTH_WORDS];

    logic [ADDR_W-1:0]   i_idx;
    logic [ADDR_W-1:0]   d_idx;
    logic                i_oor;
    logic                d_oor;

    logic                w_en;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_data;
    logic [3:0]          w_be;

    // Byte-offset bits are irrelevant to word-wide accesses.
    logic                unused_byte_offsets;
    assign unused_byte_offsets = ^{bus.IMEM_addr[1:0], bus.DMEM_addr[1:0]};

    assign i_idx = bus.IMEM_addr[ADDR_W+1:2];
    assign d_idx = bus.DMEM_addr[ADDR_W+1:2];
    assign i_oor = |bus.IMEM_addr[31:ADDR_W+2];
    assign d_oor = |bus.DMEM_addr[31:ADDR_W+2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= LOAD;
            ld_ptr <= '0;
        end else begin
            state  <= next_state;
            ld_ptr <= next_ptr;
        end
    end

    // The last memory word ends the image even without Load_last; the pointer
    // saturates there so it never wraps back onto word 0.
    always_comb begin
        next_state       = state;
        next_ptr         = ld_ptr;
        handshake        = 1'b0;
        bus.Load_ready   = 1'b0;
        bus.Core_reset_n = 1'b0;
        bus.Load_done    = 1'b0;
        case (state)
            LOAD: begin
                bus.Load_ready = 1'b1;
                handshake      = bus.Load_valid;
                if (handshake) begin
                    if (ld_ptr != ADDR_W'(DEPTH_WORDS - 1)) begin
                        next_ptr = ld_ptr + ADDR_W'(1);
                    end
                    if (bus.Load_last || ld_ptr == ADDR_W'(DEPTH_WORDS - 1)) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                bus.Core_reset_n = 1'b1;
                bus.Load_done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Single write port: loader owns it in LOAD, the core owns it in RUN.
    // A write in the same cycle as Reset is dropped.
    always_comb begin
        w_en   = 1'b0;
        w_idx  = ld_ptr;
        w_data = bus.Load_data;
        w_be   = 4'hF;
        if (!Reset) begin
            if (state == LOAD) begin
                w_en = handshake;
            end else begin
                w_en   = bus.DMEM_wr_en && !d_oor;
                w_idx  = d_idx;
                w_data = bus.DMEM_wr_data;
                w_be   = bus.DMEM_wr_byte_en;
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_en && w_be[b]) begin
                mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write lands, so a same-word
    // read-during-write returns the previous contents.
    always_ff @(posedge Clk) begin
        if (Reset || state == LOAD) begin
            bus.IMEM_data    <= '0;
            bus.DMEM_rd_data <= '0;
            bus.Addr_fault   <= 1'b0;
        end else begin
            bus.IMEM_data    <= i_oor ? '0 : mem[i_idx];
            bus.DMEM_rd_data <= (bus.DMEM_rst || d_oor) ? '0 : mem[d_idx];
            bus.Addr_fault   <= i_oor || d_oor;
        end
    end

endmodule

// File: tb/tb_toast_boot_mem.sv
// tb/tb_toast_boot_mem.sv - scoreboard bench for toast_boot_mem
module tb_toast_boot_mem;
    localparam int DEPTH = 16384;
    localparam int AW    = 14;

    localparam int S_IMEM = 0;
    localparam int S_DMEM = 1;
    localparam int S_FLT  = 2;
    localparam int S_CRN  = 3;
    localparam int S_DONE = 4;
    localparam int S_LRDY = 5;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    toast_boot_mem_if bus_i ();

    toast_boot_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_i)
    );

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [int];
    int          mdl_ptr;
    bit          mdl_run;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sig);
        case (sig)
            S_IMEM:  return bus_i.IMEM_data;
            S_DMEM:  return bus_i.DMEM_rd_data;
            S_FLT:   return {31'd0, bus_i.Addr_fault};
            S_CRN:   return {31'd0, bus_i.Core_reset_n};
            S_DONE:  return {31'd0, bus_i.Load_done};
            default: return {31'd0, bus_i.Load_ready};
        endcase
    endfunction

    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t        e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sig);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %h expected %h", e.name, cyc, a, e.val);
            end
        end
    end

    task automatic expect_at(input int due, input int sig, input logic [31:0] v, input string n);
        exp_t e;
        e.due = due; e.sig = sig; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic reset_cycle(input bit try_write);
        step();
        Reset                 = 1'b1;
        bus_i.Load_valid      = try_write;
        bus_i.Load_data       = 32'hBAD0BAD0;
        bus_i.Load_last       = 1'b1;
        bus_i.DMEM_wr_en      = try_write;
        bus_i.DMEM_addr       = 32'h2004;
        bus_i.DMEM_wr_data    = 32'h5555AAAA;
        bus_i.DMEM_wr_byte_en = 4'hF;
        bus_i.DMEM_rst        = 1'b0;
        bus_i.IMEM_addr       = 32'h0;
        mdl_run = 1'b0;
        mdl_ptr = 0;
        expect_at(cyc + 1, S_LRDY, 32'd1, "rst_load_ready");
        expect_at(cyc + 1, S_CRN,  32'd0, "rst_core_reset_n");
        expect_at(cyc + 1, S_DONE, 32'd0, "rst_load_done");
        expect_at(cyc + 1, S_IMEM, 32'd0, "rst_imem");
        expect_at(cyc + 1, S_DMEM, 32'd0, "rst_dmem");
        expect_at(cyc + 1, S_FLT,  32'd0, "rst_fault");
    endtask

    // Core traffic during LOAD must be ignored and never fault.
    task automatic load_word(input logic [31:0] data, input bit last);
        bit run_after;
        step();
        Reset                 = 1'b0;
        bus_i.Load_valid      = 1'b1;
        bus_i.Load_data       = data;
        bus_i.Load_last       = last;
        bus_i.DMEM_wr_en      = 1'b1;
        bus_i.DMEM_addr       = 32'h2000;
        bus_i.DMEM_wr_data    = $urandom;
        bus_i.DMEM_wr_byte_en = 4'hF;
        bus_i.DMEM_rst        = 1'b0;
        bus_i.IMEM_addr       = ($urandom % 2 == 0) ? 32'hFFFF0000 : 32'h4;
        expect_at(cyc, S_LRDY, 32'd1, "load_ready");
        mdl[mdl_ptr] = data;
        run_after = last || (mdl_ptr == DEPTH - 1);
        if (mdl_ptr < DEPTH - 1) mdl_ptr++;
        mdl_run = run_after;
        expect_at(cyc + 1, S_CRN,  {31'd0, run_after}, "load_core_reset_n");
        expect_at(cyc + 1, S_DONE, {31'd0, run_after}, "load_done");
        expect_at(cyc + 1, S_IMEM, 32'd0, "load_imem_zero");
        expect_at(cyc + 1, S_DMEM, 32'd0, "load_dmem_zero");
        expect_at(cyc + 1, S_FLT,  32'd0, "load_fault_zero");
    endtask

    task automatic core_cycle(input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, input logic [3:0] be,
                              input bit we, input bit drst, input bit lv);
        bit          i_oor;
        bit          d_oor;
        int          iw;
        int          dw;
        logic [31:0] w;
        step();
        Reset                 = 1'b0;
        bus_i.Load_valid      = lv;
        bus_i.Load_data       = 32'hCAFEF00D;
        bus_i.Load_last       = 1'b1;
        bus_i.IMEM_addr       = ia;
        bus_i.DMEM_addr       = da;
        bus_i.DMEM_wr_data    = wd;
        bus_i.DMEM_wr_byte_en = be;
        bus_i.DMEM_wr_en      = we;
        bus_i.DMEM_rst        = drst;
        i_oor = (ia >= 32'(DEPTH * 4));
        d_oor = (da >= 32'(DEPTH * 4));
        iw = int'(ia / 4);
        dw = int'(da / 4);
        expect_at(cyc, S_LRDY, 32'd0, "run_load_ready");
        expect_at(cyc, S_CRN,  32'd1, "run_core_reset_n");
        if (i_oor)                expect_at(cyc + 1, S_IMEM, 32'd0, "imem_oor");
        else if (mdl.exists(iw))  expect_at(cyc + 1, S_IMEM, mdl[iw], "imem_read");
        if (drst || d_oor)        expect_at(cyc + 1, S_DMEM, 32'd0, "dmem_zero");
        else if (mdl.exists(dw))  expect_at(cyc + 1, S_DMEM, mdl[dw], "dmem_read");
        expect_at(cyc + 1, S_FLT, {31'd0, i_oor || d_oor}, "addr_fault");
        if (we && !d_oor) begin
            w = mdl.exists(dw) ? mdl[dw] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            end
            mdl[dw] = w;
        end
    endtask

    function automatic logic [31:0] rand_addr(input int oor_one_in, input bit any_word);
        logic [31:0] a;
        int          r;
        if ($urandom % oor_one_in == 0) begin
            a = {16'($urandom_range(1, 65535)), 16'($urandom)};
        end else if (any_word) begin
            a = 32'($urandom % DEPTH) * 4 + 32'($urandom % 4);
        end else begin
            r = int'($urandom % 19);
            if (r < 3) a = 32'(r) * 4;
            else       a = (32'h800 + 32'(r - 3)) * 4;
            a = a + 32'($urandom % 4);
        end
        return a;
    endfunction

    initial begin
        Reset = 1'b1;
        bus_i.Load_valid = 1'b0; bus_i.Load_data = '0; bus_i.Load_last = 1'b0;
        bus_i.IMEM_addr = '0; bus_i.DMEM_addr = '0; bus_i.DMEM_wr_data = '0;
        bus_i.DMEM_wr_byte_en = '0; bus_i.DMEM_wr_en = 1'b0; bus_i.DMEM_rst = 1'b0;
        mdl_ptr = 0; mdl_run = 1'b0;

        reset_cycle(1'b0);

        load_word(32'h00000013, 1'b0);
        load_word(32'h00100093, 1'b0);
        load_word(32'hDEADBEEF, 1'b1);
        core_cycle(32'h8, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        core_cycle(32'h0, 32'h2000, 32'h11223344, 4'hF,    1'b1, 1'b0, 1'b0);
        core_cycle(32'h0, 32'h2000, 32'hAABBCCDD, 4'b0110, 1'b1, 1'b0, 1'b0);
        core_cycle(32'h2003, 32'h2000, 32'h12345678, 4'b0000, 1'b1, 1'b0, 1'b0);
        core_cycle(32'h2000, 32'h2000, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 1'b0);
        core_cycle(32'h2000, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        core_cycle(32'h0, 32'h00010000, 32'h77777777, 4'hF, 1'b1, 1'b0, 1'b0);
        core_cycle(32'h0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        core_cycle(32'h80000000, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        core_cycle(32'h4, 32'h2000, 32'h01020304, 4'hF, 1'b1, 1'b1, 1'b0);
        core_cycle(32'h4, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        for (int w = 32'h801; w <= 32'h80F; w++) begin
            core_cycle(32'h0, 32'(w) * 4, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        end
        for (int n = 0; n < 400; n++) begin
            core_cycle(rand_addr(8, 1'b0), rand_addr(10, 1'b0), $urandom,
                       4'($urandom), ($urandom % 2) == 1, ($urandom % 8) == 0, 1'b0);
        end

        reset_cycle(1'b1);
        load_word(32'hA5A5A5A5, 1'b1);
        core_cycle(32'h4, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        core_cycle(32'h0, 32'h2004, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        reset_cycle(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            load_word($urandom, 1'b0);
        end
        core_cycle(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 100; n++) begin
            core_cycle(rand_addr(16, 1'b1), rand_addr(16, 1'b1), $urandom,
                       4'($urandom), ($urandom % 2) == 1, ($urandom % 8) == 0, 1'b1);
        end
        core_cycle(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
